// File: rtl/demux_pkg.sv
// Shared definitions for the 4-channel stream demultiplexer and its per-channel FIFOs.
package demux_pkg;

  localparam int NUM_CH     = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } ch_state_t;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry channel FIFO: slot 0 is the head presented to the consumer, slot 1 the tail.
module demux_fifo2
  import demux_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  ch_state_t         state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  // A push into a FULL channel only lands when the head leaves in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            mem[0] <= push_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            mem[0] <= push_data;
          end else if (push) begin
            mem[1] <= push_data;
            state  <= FULL;
          end else if (pop) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            mem[0] <= mem[1];
            if (push) mem[1] <= push_data;
            else      state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign full      = (state == FULL);
  assign empty     = (state == EMPTY);
  assign head_data = mem[0];

endmodule

// File: rtl/demux4_stream.sv
// Routes one valid/ready input stream to four independently buffered output channels.
// Build option: define DEMUX4_STREAM_STATS_EN to add per-channel saturating pop counters (xfer_count).
module demux4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_select,
  input  logic [DATA_W-1:0]       in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [DATA_W-1:0]       out_data0,
  output logic [DATA_W-1:0]       out_data1,
  output logic [DATA_W-1:0]       out_data2,
  output logic [DATA_W-1:0]       out_data3
`ifdef DEMUX4_STREAM_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] xfer_count
`endif
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W-1:0] head [NUM_CH];

  // A full channel still accepts when its consumer drains the head this same cycle.
  assign in_ready = !full[in_select] || out_ready[in_select];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push[k] = in_valid && in_ready && (in_select == k[1:0]);
    assign pop[k]  = out_ready[k] && !empty[k];

    demux_fifo2 #(.DATA_W(DATA_W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[k]),
      .pop       (pop[k]),
      .push_data (in_data),
      .full      (full[k]),
      .empty     (empty[k]),
      .head_data (head[k])
    );
  end

  assign out_valid = ~empty;
  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];

`ifdef DEMUX4_STREAM_STATS_EN
  logic [NUM_CH*CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (pop[k] && (cnt_q[k*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          cnt_q[k*CNT_W +: CNT_W] <= cnt_q[k*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

  assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Directed self-checking bench for demux4_stream; stats checks run when DEMUX4_STREAM_STATS_EN is defined.
module tb_demux4_stream;

  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_select;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data0;
  logic [DATA_W-1:0] out_data1;
  logic [DATA_W-1:0] out_data2;
  logic [DATA_W-1:0] out_data3;
`ifdef DEMUX4_STREAM_STATS_EN
  logic [63:0]       xfer_count;
`endif

  int num_compared   = 0;
  int num_mismatched = 0;

  demux4_stream #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_select (in_select),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef DEMUX4_STREAM_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_compared++;
    if (obs !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] sel,
                               input logic [DATA_W-1:0] d, input logic [3:0] rdy);
    in_valid  = v;
    in_select = sel;
    in_data   = d;
    out_ready = rdy;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, '0, 4'b0000);
    tick();
    checkOutput("rst_out_valid", {60'd0, out_valid}, 64'h0);
    checkOutput("rst_out_data0", {32'd0, out_data0}, 64'h0);
    checkOutput("rst_out_data3", {32'd0, out_data3}, 64'h0);
    for (int s = 0; s < 4; s++) begin
      in_select = s[1:0];
      #1;
      checkOutput($sformatf("rst_in_ready_sel%0d", s), {63'd0, in_ready}, 64'h1);
    end
    tick();
    reset = 1'b0;
    tick();

    // Single word on channel 2 held while its consumer stalls.
    applyStimulus(1'b1, 2'd2, 32'hA5A5_A5A5, 4'b0000);
    tick();
    applyStimulus(1'b0, 2'd1, 32'hDEAD_BEEF, 4'b0000);
    checkOutput("ch2_out_valid", {60'd0, out_valid}, 64'h4);
    checkOutput("ch2_out_data", {32'd0, out_data2}, 64'hA5A5_A5A5);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("ch2_hold%0d", i), {28'd0, out_valid, out_data2}, {28'd0, 4'h4, 32'hA5A5_A5A5});
    end
    applyStimulus(1'b0, 2'd0, '0, 4'b0100);
    tick();
    checkOutput("ch2_drained", {60'd0, out_valid}, 64'h0);

    // Channel 1 fills up; channel 3 still accepts.
    applyStimulus(1'b1, 2'd1, 32'h1111_0001, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd1, 32'h1111_0002, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd1, 32'h1111_0003, 4'b0000);
    #1;
    checkOutput("ch1_full_in_ready", {63'd0, in_ready}, 64'h0);
    tick();
    applyStimulus(1'b1, 2'd3, 32'h3333_0001, 4'b0000);
    #1;
    checkOutput("ch3_in_ready", {63'd0, in_ready}, 64'h1);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 4'b0000);
    checkOutput("ch1_ch3_valid", {60'd0, out_valid}, 64'hA);
    checkOutput("ch1_head", {32'd0, out_data1}, 64'h1111_0001);
    checkOutput("ch3_head", {32'd0, out_data3}, 64'h3333_0001);
    applyStimulus(1'b0, 2'd0, '0, 4'b1010);
    tick();
    checkOutput("ch1_second", {32'd0, out_data1}, 64'h1111_0002);
    checkOutput("ch1_after_pop_valid", {60'd0, out_valid}, 64'h2);
    tick();
    checkOutput("ch1_no_third", {60'd0, out_valid}, 64'h0);

    // Channel 0 full, simultaneous push and pop.
    applyStimulus(1'b1, 2'd0, 32'h0000_0001, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd0, 32'h0000_0002, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd0, 32'h0000_0003, 4'b0001);
    #1;
    checkOutput("ch0_full_pass_ready", {63'd0, in_ready}, 64'h1);
    checkOutput("ch0_pop_word1", {32'd0, out_data0}, 64'h1);
    tick();
    applyStimulus(1'b1, 2'd0, 32'h0000_0004, 4'b0000);
    #1;
    checkOutput("ch0_still_full", {63'd0, in_ready}, 64'h0);
    checkOutput("ch0_pop_word2", {32'd0, out_data0}, 64'h2);
    applyStimulus(1'b0, 2'd0, '0, 4'b0001);
    tick();
    checkOutput("ch0_pop_word3", {32'd0, out_data0}, 64'h3);
    checkOutput("ch0_valid_w3", {60'd0, out_valid}, 64'h1);
    tick();
    checkOutput("ch0_empty", {60'd0, out_valid}, 64'h0);

    // Channel 2 in ONE, push and pop together.
    applyStimulus(1'b1, 2'd2, 32'h2222_000A, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd2, 32'h2222_000B, 4'b0100);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 4'b0000);
    checkOutput("ch2_one_pushpop", {28'd0, out_valid, out_data2}, {28'd0, 4'h4, 32'h2222_000B});
    applyStimulus(1'b0, 2'd0, '0, 4'b0100);
    tick();
    checkOutput("ch2_one_drained", {60'd0, out_valid}, 64'h0);

    // Asynchronous reset with channels 0 and 3 occupied.
    applyStimulus(1'b1, 2'd0, 32'h0000_00C0, 4'b0000);
    tick();
    applyStimulus(1'b1, 2'd3, 32'h0000_00C3, 4'b0000);
    tick();
    applyStimulus(1'b0, 2'd0, '0, 4'b0000);
    checkOutput("pre_reset_valid", {60'd0, out_valid}, 64'h9);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_valid", {60'd0, out_valid}, 64'h0);
    checkOutput("async_reset_data0", {32'd0, out_data0}, 64'h0);
    tick();
    #2;
    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, '0, 4'b1111);
    tick();
    tick();
    checkOutput("no_replay", {60'd0, out_valid}, 64'h0);

`ifdef DEMUX4_STREAM_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, '0, 4'b0000);
    checkOutput("stats_reset", xfer_count, 64'h0);
    applyStimulus(1'b1, 2'd1, 32'h5555_5555, 4'b0010);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("stats_four_pops", xfer_count, 64'h0000_0000_0004_0000);
    for (int i = 0; i < 70000; i++) tick();
    checkOutput("stats_saturated", xfer_count, 64'h0000_0000_FFFF_0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule

// File: doc/demux4_stream.md
DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the data width of every channel.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream offers a word.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-006 SHALL have port in_select, input, 2 bits: destination channel 0..3 for the offered word.
REQ-007 SHALL have port in_data, input, DATA_W bits: the offered word.
REQ-008 SHALL have ports out_valid, output, 4 bits: bit k means channel k holds a word.
REQ-009 SHALL have ports out_ready, input, 4 bits: bit k means consumer k takes its word.
REQ-010 SHALL have ports out_data0..out_data3, outputs, DATA_W bits each: the head word of each channel.

Function
REQ-011 SHALL treat a transfer as valid AND ready sampled on the same rising clk edge, on both sides.
REQ-012 SHALL give each channel an independent 2-entry FIFO, with states EMPTY, ONE, and FULL.
REQ-013 SHALL drive in_ready = NOT FULL of channel in_select, OR FULL with out_ready[in_select] high (pass-through slot frees).
REQ-014 SHALL make in_ready independent of in_valid; in_ready depends combinationally on in_select and out_ready only.
REQ-015 SHALL present an accepted word on out_dataK with out_valid[K]=1 on the cycle after acceptance (latency 1).
REQ-016 SHALL deliver words on each channel in acceptance order; channels do not block each other.
REQ-017 SHALL NOT change out_dataK while out_valid[K]=1 and out_ready[K]=0.
REQ-018 SHALL handle simultaneous push and pop on one channel: in ONE, state stays ONE with the new word at the head next cycle; in FULL, state stays FULL.
REQ-019 SHALL leave state unchanged when out_ready[K]=1 with channel K EMPTY.
REQ-020 SHALL ignore in_select and in_data when in_valid=0.

Reset
REQ-021 SHALL, while reset=1, force all channels EMPTY, out_valid=4'b0000, and out_data0..3=0.
REQ-022 SHALL discard any words held when reset asserts mid-operation; nothing is replayed.
REQ-023 SHALL allow in_ready to follow REQ-013 during reset; no transfer is recorded while reset=1.

Configuration
REQ-024 SHALL, with DEMUX4_STREAM_STATS_EN defined, add one output xfer_count, 4x16 bits (channel k in bits 16k+15:16k), giving saturating counts of words popped per channel, reset to 0.
REQ-025 SHALL, without DEMUX4_STREAM_STATS_EN, omit the xfer_count port and its counter logic entirely, with all other behaviour identical.

Structure
REQ-026 SHALL take the channel count (4), FIFO depth (2), the channel-state enumerated type (EMPTY/ONE/FULL), and the counter width (16) from shared package demux_pkg.
REQ-027 SHALL implement each channel as sub-module demux_fifo2 with push/pop/full/empty, instantiated 4 times.

Verification
REQ-028 SHALL check: reset -> out_valid=0000, in_ready=1 for every in_select.
REQ-029 SHALL check: push 0xA5A5A5A5 to channel 2 with out_ready=0 -> next cycle out_valid=0100 and out_data2=0xA5A5A5A5, held stable for 5 cycles.
REQ-030 SHALL check: push 3 words to channel 1 with out_ready[1]=0 -> third offer sees in_ready=0, while a channel 3 push in the same state is accepted.
REQ-031 SHALL check: channel 0 FULL, push and pop in the same cycle -> both accepted, channel stays FULL, and order is preserved (pop sees word 1, then word 2, then word 3).
REQ-032 SHALL check: reset pulse with channels 0 and 3 non-empty -> out_valid=0000 immediately, asynchronously and before the next clk edge.
REQ-033 SHALL check, with DEMUX4_STREAM_STATS_EN defined: 70000 pops on channel 1 -> xfer_count channel 1 field = 0xFFFF, other fields = 0.
